// File: rtl/tcdm_bank_responder_pkg.sv
// Shared TCDM word types (mempool slice) and sizing helpers for the bank responder.
package mempool_pkg;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned TCDMAddrMemWidth = 10;

  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [DataWidth/8-1:0]      be_t;
  typedef logic [TCDMAddrMemWidth-1:0] tcdm_addr_t;
endpackage

package tcdm_bank_responder_pkg;
  // Index width for a structure of n entries; never narrower than one bit.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the values 0..n inclusive.
  function automatic int unsigned credit_width(int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/tcdm_bank_responder_if.sv
// TCDM slave-port request/grant bundle plus the response valid/ready channel.
interface tcdm_bank_responder_if #(
  parameter int unsigned AddrMemWidth = mempool_pkg::TCDMAddrMemWidth,
  parameter int unsigned DataWidth    = 32
);
  logic                    req_i;
  logic                    gnt_o;
  logic [AddrMemWidth-1:0] addr_i;
  logic                    wen_i;
  logic [DataWidth-1:0]    wdata_i;
  logic [DataWidth/8-1:0]  be_i;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic [DataWidth-1:0]    resp_rdata_o;
  logic                    resp_write_o;

  modport master (
    output req_i, addr_i, wen_i, wdata_i, be_i, resp_ready_i,
    input  gnt_o, resp_valid_o, resp_rdata_o, resp_write_o
  );

  modport slave (
    input  req_i, addr_i, wen_i, wdata_i, be_i, resp_ready_i,
    output gnt_o, resp_valid_o, resp_rdata_o, resp_write_o
  );
endinterface

// File: rtl/tcdm_bank_resp_fifo.sv
// Response FIFO: registered head, no fall-through, occupancy count separates full from empty.
module tcdm_bank_resp_fifo import tcdm_bank_responder_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] head_o
);
  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = credit_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop_i && (count_q != '0);
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CntW'(push_i) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Credits upstream bound occupancy, so a push into a full FIFO is a design bug.
  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count_q == CntW'(Depth))));
endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: grants requests against a credit budget, tracks SRAM latency, buffers responses.
module tcdm_bank_responder import tcdm_bank_responder_pkg::*; #(
  parameter int unsigned AddrMemWidth   = mempool_pkg::TCDMAddrMemWidth,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MemLatency     = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteResp      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tcdm_bank_responder_if.slave    bus,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrMemWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]    sram_wdata_o,
  output logic [DataWidth/8-1:0]  sram_be_o,
  input  logic [DataWidth-1:0]    sram_rdata_i
);
  localparam int unsigned CreditW = credit_width(MaxOutstanding);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 write;
  } resp_t;

  logic                  resp_bearing;
  logic                  gnt;
  logic                  take;
  logic                  pop;
  logic                  push;
  logic                  head_valid;
  resp_t                 push_resp;
  resp_t                 head_resp;
  logic [CreditW-1:0]    credits_q, credits_d;
  logic [MemLatency-1:0] tag_valid_q, tag_valid_d;
  logic [MemLatency-1:0] tag_write_q, tag_write_d;

  always_comb begin
    resp_bearing = !bus.wen_i || WriteResp;
    gnt  = bus.req_i && !rst_i &&
           (!resp_bearing || (credits_q < CreditW'(MaxOutstanding)));
    take = gnt && resp_bearing;
    pop  = head_valid && bus.resp_ready_i;

    tag_valid_d    = '0;
    tag_write_d    = '0;
    tag_valid_d[0] = take;
    tag_write_d[0] = bus.wen_i;
    for (int unsigned i = 1; i < MemLatency; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_write_d[i] = tag_write_q[i-1];
    end

    push            = tag_valid_q[MemLatency-1];
    push_resp.write = tag_write_q[MemLatency-1];
    push_resp.rdata = tag_write_q[MemLatency-1] ? '0 : sram_rdata_i;

    credits_d = credits_q + CreditW'(take) - CreditW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q   <= '0;
      tag_valid_q <= '0;
      tag_write_q <= '0;
    end else begin
      credits_q   <= credits_d;
      tag_valid_q <= tag_valid_d;
      tag_write_q <= tag_write_d;
    end
  end

  tcdm_bank_resp_fifo #(
    .Depth (MaxOutstanding),
    .Width ($bits(resp_t))
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_resp),
    .pop_i       (pop),
    .valid_o     (head_valid),
    .head_o      (head_resp)
  );

  assign bus.gnt_o        = gnt;
  assign bus.resp_valid_o = head_valid;
  assign bus.resp_rdata_o = head_resp.rdata;
  assign bus.resp_write_o = head_resp.write;

  assign sram_req_o   = gnt;
  assign sram_we_o    = bus.wen_i;
  assign sram_addr_o  = bus.addr_i;
  assign sram_wdata_o = bus.wdata_i;
  assign sram_be_o    = bus.be_i;
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: three configurations checked cycle by cycle against a queue model.
module tb_tcdm_bank_responder;
  localparam int unsigned AW = mempool_pkg::TCDMAddrMemWidth;
  localparam int NI = 3;

  typedef struct {
    logic [31:0] d;
    bit          w;
    int          avail;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s   [NI];
  logic          req_s   [NI];
  logic          wen_s   [NI];
  logic [AW-1:0] addr_s  [NI];
  logic [31:0]   wdata_s [NI];
  logic [3:0]    be_s    [NI];
  logic          ready_s [NI];

  logic          gnt_w    [NI];
  logic          valid_w  [NI];
  logic          write_w  [NI];
  logic [31:0]   rdata_w  [NI];
  logic          sreq_w   [NI];
  logic          swe_w    [NI];
  logic [AW-1:0] saddr_w  [NI];
  logic [31:0]   swdata_w [NI];
  logic [3:0]    sbe_w    [NI];

  int lat [NI] = '{1, 1, 3};
  bit wr  [NI] = '{1'b0, 1'b1, 1'b0};

  function automatic logic [31:0] init_word(int a);
    return 32'h1000_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int unsigned L  = (k == 2) ? 3 : 1;
    localparam bit          WR = (k == 1);

    tcdm_bank_responder_if #(.AddrMemWidth(AW), .DataWidth(32)) bus ();
    logic [31:0] sram_rdata;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [L];

    assign bus.req_i        = req_s[k];
    assign bus.addr_i       = addr_s[k];
    assign bus.wen_i        = wen_s[k];
    assign bus.wdata_i      = wdata_s[k];
    assign bus.be_i         = be_s[k];
    assign bus.resp_ready_i = ready_s[k];
    assign gnt_w[k]         = bus.gnt_o;
    assign valid_w[k]       = bus.resp_valid_o;
    assign rdata_w[k]       = bus.resp_rdata_o;
    assign write_w[k]       = bus.resp_write_o;

    tcdm_bank_responder #(
      .AddrMemWidth   (AW),
      .DataWidth      (32),
      .MemLatency     (L),
      .MaxOutstanding (4),
      .WriteResp      (WR)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_s[k]),
      .bus          (bus.slave),
      .sram_req_o   (sreq_w[k]),
      .sram_we_o    (swe_w[k]),
      .sram_addr_o  (saddr_w[k]),
      .sram_wdata_o (swdata_w[k]),
      .sram_be_o    (sbe_w[k]),
      .sram_rdata_i (sram_rdata)
    );

    // SRAM stub: byte-enabled writes, reads appear L cycles after the strobe.
    initial for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
      if (sreq_w[k] && swe_w[k])
        for (int b = 0; b < 4; b++)
          if (sbe_w[k][b]) mem[saddr_w[k]][8*b +: 8] <= swdata_w[k][8*b +: 8];
      pipe[0] <= (sreq_w[k] && !swe_w[k]) ? mem[saddr_w[k]] : 32'hBADC_0FFE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata = pipe[L-1];
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        expq [NI][$];
  int          outst [NI];
  logic [31:0] mmem [NI][1024];
  int          gnt_cnt [NI];
  int          pop_cnt [NI];
  int          first_pop [NI];
  int          last_pop [NI];

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  // Compare every instance against the model for the current cycle, then advance the model across the edge.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit   rb, eg, ev;
      exp_t e;
      rb = !wen_s[k] || wr[k];
      eg = req_s[k] && !rst_s[k] && (!rb || outst[k] < 4);
      chk("gnt", k, 32'(gnt_w[k]), 32'(eg));
      chk("sram_req", k, 32'(sreq_w[k]), 32'(eg));
      if (eg) begin
        chk("sram_we", k, 32'(swe_w[k]), 32'(wen_s[k]));
        chk("sram_addr", k, 32'(saddr_w[k]), 32'(addr_s[k]));
        if (wen_s[k]) begin
          chk("sram_wdata", k, swdata_w[k], wdata_s[k]);
          chk("sram_be", k, 32'(sbe_w[k]), 32'(be_s[k]));
        end
      end
      ev = (expq[k].size() > 0) && (expq[k][0].avail <= cyc);
      chk("resp_valid", k, 32'(valid_w[k]), 32'(ev));
      if (ev) begin
        chk("resp_rdata", k, rdata_w[k], expq[k][0].d);
        chk("resp_write", k, 32'(write_w[k]), 32'(expq[k][0].w));
      end
      if (gnt_w[k]) gnt_cnt[k]++;
      if (valid_w[k] && ready_s[k]) begin
        pop_cnt[k]++;
        if (first_pop[k] < 0) first_pop[k] = cyc;
        last_pop[k] = cyc;
      end
      if (rst_s[k]) begin
        expq[k].delete();
        outst[k] = 0;
      end else begin
        if (ev && ready_s[k]) begin
          void'(expq[k].pop_front());
          outst[k]--;
        end
        if (eg) begin
          if (wen_s[k])
            for (int b = 0; b < 4; b++)
              if (be_s[k][b]) mmem[k][addr_s[k]][8*b +: 8] = wdata_s[k][8*b +: 8];
          if (rb) begin
            e.d     = wen_s[k] ? 32'h0 : mmem[k][addr_s[k]];
            e.w     = wen_s[k];
            e.avail = cyc + lat[k] + 1;
            expq[k].push_back(e);
            outst[k]++;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int k, bit we, int a, logic [31:0] wd, logic [3:0] be);
    req_s[k]   = 1'b1;
    wen_s[k]   = we;
    addr_s[k]  = AW'(a);
    wdata_s[k] = wd;
    be_s[k]    = be;
  endtask

  task automatic clr(int k);
    req_s[k] = 1'b0;
    wen_s[k] = 1'b0;
  endtask

  int g0, p0;

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; wen_s[k] = 1'b0; addr_s[k] = '0;
      wdata_s[k] = '0; be_s[k] = '0; ready_s[k] = 1'b1;
      outst[k] = 0; gnt_cnt[k] = 0; pop_cnt[k] = 0; first_pop[k] = -1; last_pop[k] = -1;
      for (int i = 0; i < 1024; i++) mmem[k][i] = init_word(i);
    end
    repeat (2) begin @(posedge clk); #1; end
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("rst_valid", k, 32'(valid_w[k]), 32'h0);
      chk("rst_rdata", k, rdata_w[k], 32'h0);
      chk("rst_write", k, 32'(write_w[k]), 32'h0);
      rst_s[k] = 1'b0;
    end

    // Write then read back on the latency-1 instance.
    set_req(0, 1'b1, 'h10, 32'hDEAD_BEEF, 4'hF); tick();
    set_req(0, 1'b0, 'h10, 32'h0, 4'h0); tick();
    clr(0);
    chk("t1_valid_g+1", 0, 32'(valid_w[0]), 32'h0);
    tick();
    chk("t1_valid_g+2", 0, 32'(valid_w[0]), 32'h1);
    chk("t1_rdata", 0, rdata_w[0], 32'hDEAD_BEEF);
    chk("t1_write", 0, 32'(write_w[0]), 32'h0);
    repeat (2) tick();
    chk("t1_resp_count", 0, 32'(pop_cnt[0]), 32'd1);

    // Ten back-to-back reads.
    g0 = gnt_cnt[0]; p0 = pop_cnt[0]; first_pop[0] = -1;
    for (int a = 0; a < 10; a++) begin set_req(0, 1'b0, a, 32'h0, 4'h0); tick(); end
    clr(0);
    chk("t2_grants", 0, 32'(gnt_cnt[0] - g0), 32'd10);
    repeat (4) tick();
    chk("t2_resps", 0, 32'(pop_cnt[0] - p0), 32'd10);
    chk("t2_resp_span", 0, 32'(last_pop[0] - first_pop[0]), 32'd9);

    // Back-pressure: credits run out, writes still pass, grants resume one per pop.
    ready_s[0] = 1'b0; g0 = gnt_cnt[0];
    for (int a = 0; a < 8; a++) begin set_req(0, 1'b0, 'h40 + a, 32'h0, 4'h0); tick(); end
    chk("t3_grant_window", 0, 32'(gnt_cnt[0] - g0), 32'd4);
    g0 = gnt_cnt[0];
    set_req(0, 1'b1, 'h50, 32'hCAFE_F00D, 4'hF); tick();
    chk("t3_write_gnt", 0, 32'(gnt_cnt[0] - g0), 32'd1);
    ready_s[0] = 1'b1; g0 = gnt_cnt[0]; p0 = pop_cnt[0];
    for (int a = 0; a < 8; a++) begin set_req(0, 1'b0, 'h50 + a, 32'h0, 4'h0); tick(); end
    chk("t3_regrants", 0, 32'(gnt_cnt[0] - g0), 32'd7);
    chk("t3_pops", 0, 32'(pop_cnt[0] - p0), 32'd8);
    clr(0);
    repeat (4) tick();

    // Reset with three responses buffered and one in flight.
    ready_s[0] = 1'b0;
    for (int a = 0; a < 4; a++) begin set_req(0, 1'b0, 'h60 + a, 32'h0, 4'h0); tick(); end
    clr(0); rst_s[0] = 1'b1; tick();
    rst_s[0] = 1'b0;
    chk("t5_valid_after_rst", 0, 32'(valid_w[0]), 32'h0);
    ready_s[0] = 1'b1; p0 = pop_cnt[0];
    repeat (4) tick();
    chk("t5_no_stale", 0, 32'(pop_cnt[0] - p0), 32'd0);
    ready_s[0] = 1'b0; g0 = gnt_cnt[0];
    for (int a = 0; a < 6; a++) begin set_req(0, 1'b0, 'h70 + a, 32'h0, 4'h0); tick(); end
    chk("t5_window_restored", 0, 32'(gnt_cnt[0] - g0), 32'd4);
    clr(0); ready_s[0] = 1'b1;
    repeat (6) tick();

    // Write responses: byte-enabled write then read, then writes consume credits.
    set_req(1, 1'b1, 'h20, 32'h1234_5678, 4'h3); tick();
    set_req(1, 1'b0, 'h20, 32'h0, 4'h0); tick();
    clr(1);
    chk("t4_wresp_valid", 1, 32'(valid_w[1]), 32'h1);
    chk("t4_wresp_write", 1, 32'(write_w[1]), 32'h1);
    chk("t4_wresp_rdata", 1, rdata_w[1], 32'h0);
    tick();
    chk("t4_rresp_write", 1, 32'(write_w[1]), 32'h0);
    chk("t4_rresp_rdata", 1, rdata_w[1], 32'h1000_5678);
    repeat (2) tick();
    ready_s[1] = 1'b0; g0 = gnt_cnt[1];
    for (int a = 0; a < 4; a++) begin set_req(1, 1'b1, 'h30 + a, 32'h0BAD_0000 + a, 4'hF); tick(); end
    set_req(1, 1'b0, 'h30, 32'h0, 4'h0); tick();
    chk("t4_write_credit", 1, 32'(gnt_cnt[1] - g0), 32'd4);
    clr(1); ready_s[1] = 1'b1;
    repeat (6) tick();

    // Latency-3 instance: first response four cycles after its grant.
    p0 = pop_cnt[2];
    for (int i = 0; i < 12; i++) begin
      set_req(2, 1'b0, 'h100 + i, 32'h0, 4'h0); tick();
      if (i == 2) chk("t6_valid_g+3", 2, 32'(valid_w[2]), 32'h0);
      if (i == 3) chk("t6_valid_g+4", 2, 32'(valid_w[2]), 32'h1);
      if (i == 3) chk("t6_first_rdata", 2, rdata_w[2], 32'h1001_0100);
    end
    clr(2);
    repeat (8) tick();
    chk("t6_resps", 2, 32'(pop_cnt[2] - p0), 32'd10);

    for (int k = 0; k < NI; k++) chk("drained", k, 32'(valid_w[k]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
